// File: rtl/div_sqrt_pkg.sv
// Shared state encoding, widths and the precision -> iteration-count rule
// for the iterative divide/sqrt unit (controller and result normaliser).
package div_sqrt_pkg;

  localparam int unsigned C_DIV_MANT  = 23;
  localparam int unsigned C_QUOT_BITS = C_DIV_MANT + 4;
  localparam int unsigned C_MIN_PREC  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

  // Requests below the minimum or above full precision fall back to full precision.
  function automatic int unsigned n_iter(input int unsigned prec,
                                         input int unsigned quot_bits,
                                         input int unsigned unroll);
    int unsigned q;
    q = (prec >= C_MIN_PREC && prec <= quot_bits) ? prec : quot_bits;
    return (q + unroll - 1) / unroll;
  endfunction

endpackage

// File: rtl/div_sqrt_prec_decode.sv
// Precision request -> index of the final iteration cycle (N-1).
// Latency: combinational. Backpressure: none, pure decode.
// Returns N-1 so that N == 2**C_CNT_W still fits in the counter width.
module div_sqrt_prec_decode #(
  parameter int unsigned C_QUOT_BITS   = div_sqrt_pkg::C_QUOT_BITS,
  parameter int unsigned C_ITER_UNROLL = 1,
  parameter int unsigned C_PREC_W      = 6,
  parameter int unsigned C_CNT_W       = 6
) (
  input  logic [C_PREC_W-1:0] Precision_ctl_SI,
  output logic [C_CNT_W-1:0]  Last_idx_DO
);
  import div_sqrt_pkg::*;

  assign Last_idx_DO = C_CNT_W'(n_iter(32'(Precision_ctl_SI), C_QUOT_BITS, C_ITER_UNROLL) - 1);

endmodule

// File: rtl/div_sqrt_iter_ctrl.sv
// Sequencer for the radix-2 div/sqrt mantissa iteration: operand load, mode enables, carry-in strobe, done.
// Latency: accept at t, iteration cycles t+1..t+N, Done_SO at t+N+1; Load_SO is combinational on accept.
// Backpressure: Ready_SO low while iterating and starts are dropped; DIV_SQRT_CTRL_KILL_EN enables Kill_SI abort.
module div_sqrt_iter_ctrl #(
  parameter int unsigned C_DIV_MANT    = div_sqrt_pkg::C_DIV_MANT,
  parameter int unsigned C_QUOT_BITS   = C_DIV_MANT + 4,
  parameter int unsigned C_ITER_UNROLL = 1,
  parameter int unsigned C_PREC_W      = 6,
  parameter int unsigned C_CNT_W       = 6
) (
  input  logic                Clk_CI,
  input  logic                Rst_RI,
  input  logic                Div_start_SI,
  input  logic                Sqrt_start_SI,
  input  logic [C_PREC_W-1:0] Precision_ctl_SI,
  input  logic                Kill_SI,
  output logic                Ready_SO,
  output logic                Busy_SO,
  output logic                Load_SO,
  output logic                Div_enable_SO,
  output logic                Sqrt_enable_SO,
  output logic                Div_start_dly_SO,
  output logic [C_CNT_W-1:0]  Iter_cnt_DO,
  output logic                Last_iter_SO,
  output logic                Done_SO
);
  import div_sqrt_pkg::*;

  localparam int unsigned C_N_MAX = (C_QUOT_BITS + C_ITER_UNROLL - 1) / C_ITER_UNROLL;

  if (C_ITER_UNROLL < 1 || C_ITER_UNROLL > 4) begin : g_bad_unroll
    $error("div_sqrt_iter_ctrl: C_ITER_UNROLL must be 1..4");
  end
  if (C_N_MAX > (1 << C_CNT_W)) begin : g_bad_cnt_w
    $error("div_sqrt_iter_ctrl: C_CNT_W too narrow for the iteration count");
  end

  state_e             state_q;
  logic [C_CNT_W-1:0] cnt_q, last_idx_q, dec_last_idx;
  logic               ready_q, busy_q, div_en_q, sqrt_en_q, dly_q, last_q, done_q;
  logic               kill, accept;

`ifdef DIV_SQRT_CTRL_KILL_EN
  assign kill = Kill_SI;
`else
  logic unused_kill;
  assign kill        = 1'b0;
  assign unused_kill = Kill_SI;
`endif

  div_sqrt_prec_decode #(
    .C_QUOT_BITS  (C_QUOT_BITS),
    .C_ITER_UNROLL(C_ITER_UNROLL),
    .C_PREC_W     (C_PREC_W),
    .C_CNT_W      (C_CNT_W)
  ) u_prec_decode (
    .Precision_ctl_SI(Precision_ctl_SI),
    .Last_idx_DO     (dec_last_idx)
  );

  // Divide wins when both starts arrive together; kill blocks any accept.
  assign accept = ready_q & (Div_start_SI | Sqrt_start_SI) & ~kill;

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_idx_q <= '0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      div_en_q   <= 1'b0;
      sqrt_en_q  <= 1'b0;
      dly_q      <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dly_q  <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            state_q    <= ITER;
            cnt_q      <= '0;
            last_idx_q <= dec_last_idx;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            div_en_q   <= Div_start_SI;
            sqrt_en_q  <= ~Div_start_SI;
            dly_q      <= Div_start_SI;
            last_q     <= (dec_last_idx == '0);
          end else begin
            state_q <= IDLE;
          end
        end
        ITER: begin
          if (kill) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            div_en_q  <= 1'b0;
            sqrt_en_q <= 1'b0;
            last_q    <= 1'b0;
          end else if (last_q) begin
            // Counter is left at N-1 through DONE.
            state_q   <= DONE;
            done_q    <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            div_en_q  <= 1'b0;
            sqrt_en_q <= 1'b0;
            last_q    <= 1'b0;
          end else begin
            cnt_q  <= cnt_q + 1'b1;
            last_q <= ((cnt_q + 1'b1) == last_idx_q);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Load_SO          = accept;
  assign Ready_SO         = ready_q;
  assign Busy_SO          = busy_q;
  assign Div_enable_SO    = div_en_q;
  assign Sqrt_enable_SO   = sqrt_en_q;
  assign Div_start_dly_SO = dly_q;
  assign Iter_cnt_DO      = cnt_q;
  assign Last_iter_SO     = last_q;
  assign Done_SO          = done_q;

endmodule

// File: tb/tb_div_sqrt_iter_ctrl.sv
// Bench for div_sqrt_iter_ctrl: instance 0 with unroll 1, instance 1 with unroll 2.
// Each accepted start pushes its expected cycle window; a negedge monitor checks every output cycle by cycle.
module tb_div_sqrt_iter_ctrl;
  localparam int CW = 6;
  localparam int PW = 6;

`ifdef DIV_SQRT_CTRL_KILL_EN
  localparam int KILL_ABORT = 6;
  localparam bit KILL_ON    = 1'b1;
`else
  localparam int KILL_ABORT = -1;
  localparam bit KILL_ON    = 1'b0;
`endif

  typedef struct {
    int t_acc;
    int n;
    bit div;
    int abort;
  } op_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          div_s   [2];
  logic          sqrt_s  [2];
  logic          kill_s  [2];
  logic [PW-1:0] prec_s  [2];
  logic          ready   [2];
  logic          busy    [2];
  logic          load    [2];
  logic          den     [2];
  logic          sen     [2];
  logic          dly     [2];
  logic          last    [2];
  logic          done    [2];
  logic [CW-1:0] cnt     [2];

  op_t sb [2][$];
  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;
  bit  chk_en = 1'b0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    div_sqrt_iter_ctrl #(.C_ITER_UNROLL(g + 1)) u_dut (
      .Clk_CI          (clk),
      .Rst_RI          (rst),
      .Div_start_SI    (div_s[g]),
      .Sqrt_start_SI   (sqrt_s[g]),
      .Precision_ctl_SI(prec_s[g]),
      .Kill_SI         (kill_s[g]),
      .Ready_SO        (ready[g]),
      .Busy_SO         (busy[g]),
      .Load_SO         (load[g]),
      .Div_enable_SO   (den[g]),
      .Sqrt_enable_SO  (sen[g]),
      .Div_start_dly_SO(dly[g]),
      .Iter_cnt_DO     (cnt[g]),
      .Last_iter_SO    (last[g]),
      .Done_SO         (done[g])
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: expected outputs derived from the oldest outstanding operation.
  task automatic mon(input int d);
    op_t         e;
    logic [6:0]  act, exp;
    bit          iter, fin;
    int          endc;
    act  = {ready[d], busy[d], den[d], sen[d], dly[d], last[d], done[d]};
    exp  = 7'b1000000;
    iter = 1'b0;
    fin  = 1'b0;
    e    = '{t_acc: 0, n: 0, div: 1'b0, abort: -1};
    if (sb[d].size() > 0) begin
      e    = sb[d][0];
      endc = (e.abort >= 0) ? e.abort : e.t_acc + e.n;
      if (cyc > e.t_acc && cyc <= endc) begin
        iter = 1'b1;
        exp  = {1'b0, 1'b1, e.div, !e.div, (cyc == e.t_acc + 1) && e.div,
                (cyc == e.t_acc + e.n), 1'b0};
      end
      if (e.abort < 0 && cyc == e.t_acc + e.n + 1) begin
        exp = 7'b1000001;
        fin = 1'b1;
      end
      if (e.abort >= 0 && cyc == e.abort) fin = 1'b1;
    end
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL outputs dut%0d cyc %0d: got %b want %b (rdy busy den sen dly last done)",
               d, cyc, act, exp);
    end
    if (iter) begin
      n_tests++;
      if (cnt[d] !== CW'(cyc - e.t_acc - 1)) begin
        n_fail++;
        $display("FAIL iter_cnt dut%0d cyc %0d: got %0d want %0d", d, cyc, cnt[d], cyc - e.t_acc - 1);
      end
    end
    if (fin) void'(sb[d].pop_front());
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      mon(0);
      mon(1);
    end
  end

  // One cycle of stimulus on instance d; abort_off is the cycle offset of a planned reset/kill.
  task automatic drive(input int d, input bit dv, input bit sq, input int prec, input bit kl,
                       input bit rs, input bit exp_load, input int n, input int abort_off);
    op_t e;
    @(posedge clk);
    #1;
    div_s[d]  = dv;
    sqrt_s[d] = sq;
    prec_s[d] = PW'(prec);
    kill_s[d] = kl;
    rst       = rs;
    if (exp_load) begin
      e.t_acc = cyc;
      e.n     = n;
      e.div   = dv;
      e.abort = (abort_off < 0) ? -1 : cyc + abort_off;
      sb[d].push_back(e);
    end
    @(negedge clk);
    n_tests++;
    if (load[d] !== exp_load) begin
      n_fail++;
      $display("FAIL load dut%0d cyc %0d: got %b want %b", d, cyc, load[d], exp_load);
    end
  endtask

  task automatic idle(input int d, input int k);
    for (int i = 0; i < k; i++) drive(d, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, -1);
  endtask

  int clamp_prec [7] = '{3, 40, 5, 6, 27, 26, 0};
  int clamp_n    [7] = '{27, 27, 27, 6, 27, 26, 27};

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      div_s[d]  = 1'b0;
      sqrt_s[d] = 1'b0;
      kill_s[d] = 1'b0;
      prec_s[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    n_tests++;
    if (cnt[0] !== '0 || cnt[1] !== '0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %0d/%0d want 0/0", cnt[0], cnt[1]);
    end

    // Full-precision divide: dly at t+1, last at t+27, done at t+28.
    drive(0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 27, -1);
    idle(0, 29);

    // Both starts: divide wins; starts during ITER are dropped.
    drive(0, 1'b1, 1'b1, 8, 1'b0, 1'b0, 1'b1, 8, -1);
    drive(0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, -1);
    drive(0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0, -1);
    drive(0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0, -1);
    idle(0, 7);

    // Precision clamping and range edges.
    for (int i = 0; i < 7; i++) begin
      drive(0, (i % 2) == 0, (i % 2) == 1, clamp_prec[i], 1'b0, 1'b0, 1'b1, clamp_n[i], -1);
      idle(0, clamp_n[i] + 1);
    end

    // Sqrt start held: re-accepted in each DONE cycle, no bubble.
    for (int k = 0; k < 33; k++)
      drive(0, 1'b0, 1'b1, 10, 1'b0, 1'b0, (k % 11) == 0, 10, -1);
    idle(0, 2);

    // Reset at cnt 10: back to IDLE, no done.
    drive(0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 27, 11);
    idle(0, 10);
    drive(0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 0, -1);
    idle(0, 20);

    // Kill at cnt 5: aborts only when the kill feature is built in.
    drive(0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 27, KILL_ABORT);
    idle(0, 5);
    drive(0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0, -1);
    idle(0, 23);

    // Kill alongside a start in IDLE.
    drive(0, 1'b1, 1'b0, 6, 1'b1, 1'b0, !KILL_ON, 6, -1);
    idle(0, 8);

    // Unroll 2: sqrt prec 12 -> 6 cycles; divide full -> 14; sqrt prec 7 -> 4.
    drive(1, 1'b0, 1'b1, 12, 1'b0, 1'b0, 1'b1, 6, -1);
    idle(1, 8);
    drive(1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 14, -1);
    idle(1, 16);
    drive(1, 1'b0, 1'b1, 7, 1'b0, 1'b0, 1'b1, 4, -1);
    idle(1, 6);

    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (sb[d].size() != 0) begin
        n_fail++;
        $display("FAIL pending_ops dut%0d: got %0d outstanding want 0", d, sb[d].size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_sqrt_iter_ctrl.md
Name: div_sqrt_iter_ctrl

Overview:
Sequencing controller for the radix-2 mantissa iteration datapath of the iterative FP divide/square-root unit.
- Accepts a divide or sqrt start and drives the datapath control strobes (operand load, div/sqrt enables, delayed-start carry-in) for a precision-dependent number of cycles.
- Signals completion with a done pulse.
- Sits between the FPU issue logic and the iteration chain; owns no mantissa data.

Parameters:
C_DIV_MANT, 23, mantissa width (excl. hidden bit)
C_QUOT_BITS, C_DIV_MANT+4, full-precision quotient/root bits (hidden + mantissa + guard, round, sticky)
C_ITER_UNROLL, 1, iteration stages chained per cycle (1..4)
C_PREC_W, 6, width of precision-control input
C_CNT_W, 6, iteration counter width; must hold ceil(C_QUOT_BITS/C_ITER_UNROLL)

Ports:
Clk_CI  in  1  clock
Rst_RI  in  1  reset, synchronous, active-high
Div_start_SI  in  1  request divide
Sqrt_start_SI  in  1  request square root
Precision_ctl_SI  in  C_PREC_W  requested quotient bits; 0 = full precision
Kill_SI  in  1  abort (only with optional feature)
Ready_SO  out  1  controller can accept a start this cycle
Busy_SO  out  1  iteration in progress
Load_SO  out  1  load operand registers (start accepted this cycle)
Div_enable_SO  out  1  datapath in divide mode
Sqrt_enable_SO  out  1  datapath in sqrt mode
Div_start_dly_SO  out  1  first-iteration carry-in strobe for divide
Iter_cnt_DO  out  C_CNT_W  current iteration cycle index
Last_iter_SO  out  1  final iteration cycle
Done_SO  out  1  one-cycle completion pulse

Behaviour:
- Reset: state IDLE. All outputs 0 except Ready_SO=1. Iter_cnt 0, mode flags 0. A reset asserted mid-operation returns to IDLE next edge with no Done_SO.
- Bit count Q:
  - Q = Precision_ctl_SI if 6 <= value <= C_QUOT_BITS, else Q = C_QUOT_BITS.
  - N = ceil(Q/C_ITER_UNROLL) cycles.
  - Q and the mode are latched at accept.
- Accept: Ready_SO & (Div_start_SI | Sqrt_start_SI).
  - Both starts high: divide wins, sqrt is dropped.
  - Load_SO = accept (combinational).
- FSM:
  - IDLE: Ready_SO=1. On accept -> ITER, cnt<=0, latch mode and N.
  - ITER: Busy_SO=1, Ready_SO=0.
    - Div_enable_SO or Sqrt_enable_SO held per latched mode.
    - Div_start_dly_SO=1 only in the first ITER cycle (cnt==0) in divide mode.
    - Last_iter_SO = (cnt==N-1). If Last_iter_SO -> DONE, else cnt++.
    - Starts during ITER are ignored (no queuing).
  - DONE: Done_SO=1 for exactly one cycle. Enables drop to 0, Ready_SO=1.
    - Accept in DONE -> ITER directly (back-to-back, no bubble).
    - No accept -> IDLE. Iter_cnt holds N-1 in DONE and clears on the next accept.
- Latency: accept at cycle t, ITER cycles t+1..t+N, Done_SO at t+N+1. Default (Q=27, unroll 1): Done_SO 28 cycles after accept.
- Counter never wraps; N <= 2^C_CNT_W is enforced by parameter check at elaboration.
- Enables are mutually exclusive at all times.

Optional Feature:
Macro DIV_SQRT_CTRL_KILL_EN.
- Defined: Kill_SI in ITER forces IDLE next edge with no Done_SO. In DONE, Kill_SI suppresses a same-cycle accept; Done_SO still pulses. Kill has priority over start in IDLE.
- Undefined: Kill_SI port exists but is ignored.

Decomposition:
- Shared package div_sqrt_pkg: state enum (IDLE, ITER, DONE), C_DIV_MANT, C_QUOT_BITS, minimum precision constant 6, and the function computing N from the precision input.
- One sub-module is natural: div_sqrt_prec_decode, the combinational Precision_ctl_SI -> N decoder, reusable by the result normaliser.

Test Plan:
1. Reset then Div_start_SI for 1 cycle, Precision_ctl_SI=0 -> Load_SO same cycle; Div_start_dly_SO only at t+1; Last_iter_SO at t+27; Done_SO only at t+28.
2. Sqrt_start_SI with Precision_ctl_SI=12, C_ITER_UNROLL=2 -> 6 ITER cycles; Sqrt_enable_SO high throughout; Div_start_dly_SO never high; Done_SO at t+7.
3. Div_start_SI and Sqrt_start_SI together -> divide mode only; starts pulsed during ITER ignored, Ready_SO=0 until DONE.
4. Start held high continuously -> back-to-back operations; DONE cycle re-accepts; Done_SO every N+1 cycles with no idle cycle.
5. Precision_ctl_SI=3 and =40 -> both clamp to full precision (27 cycles).
6. Rst_RI at cnt=10 -> IDLE next cycle, no Done_SO. With DIV_SQRT_CTRL_KILL_EN, Kill_SI at cnt=5 -> same result; without the macro, Kill_SI has no effect.
